// File: rtl/instr_queue.sv
// ----------------------------------------------------------------------------
// instr_queue
//   Prefetch queue between fetch and decode. Every PC that fetch presents while
//   the queue has room is sent to instruction memory. The word that returns one
//   cycle later is paired with its PC and pushed into a DEPTH-entry FIFO that
//   decode drains. A branch flush discards queued entries and the in-flight read.
//
// Ports
//   clk             clock, all state updates on posedge
//   rst_i           asynchronous reset, active-high
//   pc_i            PC from fetch
//   pc_valid_i      pc_i holds a PC to fetch this cycle
//   stall_o         queue cannot accept a PC this cycle
//   flush_i         branch taken: drop queued and in-flight entries
//   imem_req_o      instruction-memory read strobe
//   imem_addr_o     instruction-memory read address
//   imem_rdata_i    read data, valid one cycle after imem_req_o
//   instr_valid_o   head entry is valid
//   instr_o         head instruction word
//   instr_pc_o      PC of the head instruction
//   decode_ready_i  decode consumes the head this cycle
// ----------------------------------------------------------------------------
module instr_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int IW    = 16
) (
    input  logic          clk,
    input  logic          rst_i,
    input  logic [AW-1:0] pc_i,
    input  logic          pc_valid_i,
    output logic          stall_o,
    input  logic          flush_i,
    output logic          imem_req_o,
    output logic [AW-1:0] imem_addr_o,
    input  logic [IW-1:0] imem_rdata_i,
    output logic          instr_valid_o,
    output logic [IW-1:0] instr_o,
    output logic [AW-1:0] instr_pc_o,
    input  logic          decode_ready_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] FULL_LVL = (CW+1)'(DEPTH);

    logic [AW-1:0] pc_mem_r   [DEPTH];
    logic [IW-1:0] word_mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          inflight_r;
    logic [AW-1:0] inflight_pc_r;
    logic          stall_r;
    logic          stall_next_s;
    logic          valid_r;
    logic          accept_s;
    logic          push_s;
    logic          pop_s;

    // Reset is gated in so no read strobe escapes while the block is held in reset.
    assign accept_s = pc_valid_i & ~stall_r & ~flush_i & ~rst_i;
    assign push_s   = inflight_r & ~flush_i;
    assign pop_s    = valid_r & decode_ready_i & ~flush_i;

    assign imem_req_o    = accept_s;
    assign imem_addr_o   = pc_i;
    assign stall_o       = stall_r;
    assign instr_valid_o = valid_r;
    assign instr_o       = word_mem_r[rd_ptr_r];
    assign instr_pc_o    = pc_mem_r[rd_ptr_r];

    // Next occupancy of the FIFO.
    always_comb begin
        count_next_s = count_r;
        if (flush_i) begin
            count_next_s = {CW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + CW'(1);
                2'b01:   count_next_s = count_r - CW'(1);
                default: count_next_s = count_r;
            endcase
        end
    end

    // Stall once stored entries plus the outstanding read fill the queue; the
    // reserved slot is what lets a returning word always find space.
    always_comb begin
        stall_next_s = 1'b0;
        if (({1'b0, count_next_s} + {{CW{1'b0}}, accept_s}) >= FULL_LVL) begin
            stall_next_s = 1'b1;
        end else begin
            stall_next_s = 1'b0;
        end
    end

    // Control state: in-flight tracking, pointers, occupancy and registered flags.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            inflight_r    <= 1'b0;
            inflight_pc_r <= {AW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
            count_r       <= {CW{1'b0}};
            stall_r       <= 1'b0;
            valid_r       <= 1'b0;
        end else begin
            inflight_r <= accept_s;
            if (accept_s) begin
                inflight_pc_r <= pc_i;
            end else begin
                inflight_pc_r <= inflight_pc_r;
            end
            if (flush_i) begin
                wr_ptr_r <= {PW{1'b0}};
                rd_ptr_r <= {PW{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PW'(1);
                end else begin
                    wr_ptr_r <= wr_ptr_r;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PW'(1);
                end else begin
                    rd_ptr_r <= rd_ptr_r;
                end
            end
            count_r <= count_next_s;
            stall_r <= stall_next_s;
            valid_r <= (count_next_s != {CW{1'b0}});
        end
    end

    // Entry storage: the returning word is written alongside the PC that fetched it.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]   <= {AW{1'b0}};
                word_mem_r[i] <= {IW{1'b0}};
            end
        end else begin
            if (push_s) begin
                pc_mem_r[wr_ptr_r]   <= inflight_pc_r;
                word_mem_r[wr_ptr_r] <= imem_rdata_i;
            end else begin
                pc_mem_r[wr_ptr_r]   <= pc_mem_r[wr_ptr_r];
                word_mem_r[wr_ptr_r] <= word_mem_r[wr_ptr_r];
            end
        end
    end

endmodule
